// File: rtl/piano_keyboard_renderer_if.sv
// Pixel/key bus between the coordinate generator, the synthesizer key mask
// and the keyboard renderer. The master drives pixels and key state; the
// slave returns the rendered colour two cycles later.
interface piano_keyboard_renderer_if #(
  parameter int OCTAVES = 2,
  parameter int X_W     = 8,
  parameter int Y_W     = 7
);
  localparam int KEYS  = 12 * OCTAVES;
  localparam int IDX_W = $clog2(KEYS);

  logic             frame_start;
  logic [KEYS-1:0]  keys_on;
  logic             pix_valid;
  logic [X_W-1:0]   x;
  logic [Y_W-1:0]   y;
  logic             pix_valid_out;
  logic [2:0]       color;
  logic             key_hit;
  logic [IDX_W-1:0] key_idx;

  modport master (
    output frame_start, keys_on, pix_valid, x, y,
    input  pix_valid_out, color, key_hit, key_idx
  );

  modport slave (
    input  frame_start, keys_on, pix_valid, x, y,
    output pix_valid_out, color, key_hit, key_idx
  );
endinterface

// File: rtl/piano_keyboard_renderer.sv
// Two-stage pixel renderer for an on-screen piano keyboard. Stage 1 maps a
// pixel coordinate to a key (or background); stage 2 colours it from a
// per-frame snapshot of the key mask and per-key release-tail counters.
module piano_keyboard_renderer #(
  parameter int OCTAVES     = 2,
  parameter int WHITE_W     = 11,
  parameter int BLACK_HALF  = 4,
  parameter int BLACK_TOP   = 39,
  parameter int HOLD_FRAMES = 8,
  parameter int X_W         = 8,
  parameter int Y_W         = 7
) (
  input logic                       clk,
  input logic                       rst_n,
  piano_keyboard_renderer_if.slave  bus
);
  localparam int KEYS  = 12 * OCTAVES;
  localparam int IDX_W = $clog2(KEYS);
  localparam int PITCH = 7 * WHITE_W;
  localparam int SPAN  = PITCH * OCTAVES;
  localparam int TW    = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);

  // Whites followed by a black key: C, D, F, G, A (no black after E or B).
  localparam logic [6:0] BLACK_MASK = 7'b0111011;

  localparam logic [2:0] COL_RED        = 3'h4;
  localparam logic [2:0] COL_TAIL_WHITE = 3'h5;
  localparam logic [2:0] COL_TAIL_BLACK = 3'h1;
  localparam logic [2:0] COL_WHITE      = 3'h7;
  localparam logic [2:0] COL_BLACK      = 3'h0;

  // Semitone offset of white key w inside its octave.
  function automatic logic [31:0] white_semi(input logic [31:0] w);
    case (w)
      32'd0:   white_semi = 32'd0;
      32'd1:   white_semi = 32'd2;
      32'd2:   white_semi = 32'd4;
      32'd3:   white_semi = 32'd5;
      32'd4:   white_semi = 32'd7;
      32'd5:   white_semi = 32'd9;
      default: white_semi = 32'd11;
    endcase
  endfunction

  // Tail counter update: reload while sounding, otherwise count down and
  // stick at zero.
  function automatic logic [TW-1:0] tail_next(input logic [TW-1:0] cur,
                                              input logic on);
    if (on)
      tail_next = TW'(HOLD_FRAMES);
    else if (cur != '0)
      tail_next = cur - 1'b1;
    else
      tail_next = '0;
  endfunction

  logic [X_W-1:0]   x_s;
  logic [Y_W-1:0]   y_s;
  logic [31:0]      xi, yi, oct, xo, wi, ci, blk_w, semi, key_c;
  logic             blk_found, hit_c, blk_c;
  logic [IDX_W-1:0] idx_c;

  logic             vld_p1, hit_p1, blk_p1;
  logic [IDX_W-1:0] idx_p1;
  logic [2:0]       col_c;

  logic [KEYS-1:0]  snap;
  logic [TW-1:0]    tail [KEYS];

  assign x_s = bus.x;
  assign y_s = bus.y;

  // Stage 0 -> 1: coordinate to key geometry.
  always_comb begin
    xi        = 32'(x_s);
    yi        = 32'(y_s);
    oct       = xi / PITCH;
    xo        = xi % PITCH;
    wi        = xo / WHITE_W;
    ci        = xo % WHITE_W;
    blk_found = 1'b0;
    blk_w     = '0;
    for (int i = 0; i < 7; i++) begin
      if (BLACK_MASK[i] && (xo + BLACK_HALF >= (i + 1) * WHITE_W) &&
          (xo < (i + 1) * WHITE_W + BLACK_HALF)) begin
        blk_found = 1'b1;
        blk_w     = 32'(i);
      end
    end
    hit_c = 1'b0;
    blk_c = 1'b0;
    semi  = '0;
    if (xi < SPAN) begin
      if ((yi <= BLACK_TOP) && blk_found) begin
        hit_c = 1'b1;
        blk_c = 1'b1;
        semi  = white_semi(blk_w) + 32'd1;
      end else if (ci != WHITE_W - 1) begin
        hit_c = 1'b1;
        semi  = white_semi(wi);
      end
    end
    key_c = 12 * oct + semi;
    idx_c = hit_c ? IDX_W'(key_c) : '0;
  end

  // Stage 1 register: valid is reset, geometry data just follows.
  always_ff @(posedge clk) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= bus.pix_valid;
    hit_p1 <= hit_c;
    blk_p1 <= blk_c;
    idx_p1 <= idx_c;
  end

  // Key snapshot and release tails, advanced once per frame_start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap <= '0;
      for (int k = 0; k < KEYS; k++) tail[k] <= '0;
    end else if (bus.frame_start) begin
      snap <= bus.keys_on;
      for (int k = 0; k < KEYS; k++) tail[k] <= tail_next(tail[k], bus.keys_on[k]);
    end
  end

  // Stage 1 -> 2: colour from the key state as it stands after any update
  // made in the cycle the pixel entered.
  always_comb begin
    col_c = COL_BLACK;
    if (hit_p1) begin
      if (snap[idx_p1])
        col_c = COL_RED;
      else if (tail[idx_p1] != '0)
        col_c = blk_p1 ? COL_TAIL_BLACK : COL_TAIL_WHITE;
      else
        col_c = blk_p1 ? COL_BLACK : COL_WHITE;
    end
  end

  // Stage 2 register: outputs, zeroed whenever no pixel is presented.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.pix_valid_out <= 1'b0;
      bus.color         <= 3'h0;
      bus.key_hit       <= 1'b0;
      bus.key_idx       <= '0;
    end else begin
      bus.pix_valid_out <= vld_p1;
      bus.color         <= vld_p1 ? col_c : 3'h0;
      bus.key_hit       <= vld_p1 && hit_p1;
      bus.key_idx       <= (vld_p1 && hit_p1) ? idx_p1 : '0;
    end
  end
endmodule

// File: tb/tb_piano_keyboard_renderer.sv
// Testbench for piano_keyboard_renderer: scoreboard of expected pixels,
// filled when a pixel is driven and drained when pix_valid_out appears.
module tb_piano_keyboard_renderer;
  localparam int OCT  = 2;
  localparam int WW   = 11;
  localparam int BH   = 4;
  localparam int BTOP = 39;
  localparam int HOLD = 8;
  localparam int KEYS = 12 * OCT;

  typedef struct {
    logic [2:0] color;
    logic       hit;
    logic [4:0] idx;
    int         due;
    int         x;
    int         y;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  logic [KEYS-1:0] keys = '0;
  bit   snap_m [KEYS];
  int   tail_m [KEYS];
  int   semi_tab [7] = '{0, 2, 4, 5, 7, 9, 11};
  bit   blk_after [7] = '{1, 1, 0, 1, 1, 1, 0};

  piano_keyboard_renderer_if #(.OCTAVES(OCT), .X_W(8), .Y_W(7)) dut_if ();

  piano_keyboard_renderer #(
    .OCTAVES(OCT), .WHITE_W(WW), .BLACK_HALF(BH), .BLACK_TOP(BTOP),
    .HOLD_FRAMES(HOLD), .X_W(8), .Y_W(7)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dut_if.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Key lookup by walking every key's pixel span on the keyboard.
  function automatic void geom(input int xv, input int yv,
                               output bit hit, output bit blk, output int idx);
    hit = 0; blk = 0; idx = 0;
    for (int o = 0; o < OCT; o++)
      for (int w = 0; w < 7; w++) begin
        int bd;
        bd = o * 7 * WW + (w + 1) * WW;
        if (!hit && yv <= BTOP && blk_after[w] && xv >= bd - BH && xv <= bd + BH - 1) begin
          hit = 1; blk = 1; idx = 12 * o + semi_tab[w] + 1;
        end
      end
    for (int o = 0; o < OCT; o++)
      for (int w = 0; w < 7; w++) begin
        int left;
        left = o * 7 * WW + w * WW;
        if (!hit && xv >= left && xv <= left + WW - 2) begin
          hit = 1; blk = 0; idx = 12 * o + semi_tab[w];
        end
      end
  endfunction

  function automatic void model_frame(input logic [KEYS-1:0] k);
    for (int i = 0; i < KEYS; i++) begin
      if (k[i]) tail_m[i] = HOLD;
      else if (tail_m[i] > 0) tail_m[i] = tail_m[i] - 1;
      snap_m[i] = k[i];
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < KEYS; i++) begin
      snap_m[i] = 0;
      tail_m[i] = 0;
    end
  endfunction

  // One clock of stimulus; the model is updated first so a pixel sent with
  // frame_start sees the new state.
  task automatic step(input bit fs, input bit pv, input int xv, input int yv);
    exp_t e;
    bit   h, b;
    int   id;
    dut_if.frame_start = fs;
    dut_if.keys_on     = keys;
    dut_if.pix_valid   = pv;
    dut_if.x           = 8'(xv);
    dut_if.y           = 7'(yv);
    if (fs) model_frame(keys);
    if (pv) begin
      geom(xv, yv, h, b, id);
      e.hit = h;
      e.idx = h ? 5'(id) : 5'd0;
      if (!h) e.color = 3'h0;
      else if (snap_m[id]) e.color = 3'h4;
      else if (tail_m[id] > 0) e.color = b ? 3'h1 : 3'h5;
      else e.color = b ? 3'h0 : 3'h7;
      e.due = cyc + 2;
      e.x = xv;
      e.y = yv;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Output monitor: compares each valid pixel with the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dut_if.pix_valid_out) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_valid cyc=%0d col=%0h", cyc, dut_if.color);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (dut_if.color !== e.color || dut_if.key_hit !== e.hit ||
              dut_if.key_idx !== e.idx || cyc !== e.due) begin
            bad++;
            $display("FAIL pixel x=%0d y=%0d got col=%0h hit=%0b idx=%0d cyc=%0d want col=%0h hit=%0b idx=%0d cyc=%0d",
                     e.x, e.y, dut_if.color, dut_if.key_hit, dut_if.key_idx, cyc,
                     e.color, e.hit, e.idx, e.due);
          end
        end
      end else begin
        total++;
        if (dut_if.color !== 3'h0 || dut_if.key_hit !== 1'b0 || dut_if.key_idx !== 5'd0) begin
          bad++;
          $display("FAIL idle_outputs cyc=%0d col=%0h hit=%0b idx=%0d want 0", cyc,
                   dut_if.color, dut_if.key_hit, dut_if.key_idx);
        end
        if (sb.size() != 0 && sb[0].due <= cyc) begin
          exp_t e;
          e = sb.pop_front();
          total++;
          bad++;
          $display("FAIL missing_valid x=%0d y=%0d got valid=0 want valid=1 at cyc=%0d", e.x, e.y, e.due);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    dut_if.frame_start = 0; dut_if.keys_on = '0; dut_if.pix_valid = 0;
    dut_if.x = '0; dut_if.y = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (dut_if.pix_valid_out !== 1'b0 || dut_if.color !== 3'h0 ||
        dut_if.key_hit !== 1'b0 || dut_if.key_idx !== 5'd0) begin
      bad++;
      $display("FAIL reset_outputs got v=%0b col=%0h hit=%0b idx=%0d want all 0",
               dut_if.pix_valid_out, dut_if.color, dut_if.key_hit, dut_if.key_idx);
    end
    rst_n = 1'b1;
    step(0, 0, 0, 0);
  endtask

  task automatic test_static();
    step(0, 1, 0, 50);
    step(0, 1, 10, 50);
    step(0, 1, 7, 20);
    step(0, 1, 32, 20);
    step(0, 1, 18, 10);
    step(0, 1, 76, 60);
    step(0, 1, 150, 30);
    step(0, 0, 0, 0);
    step(0, 1, 66, 39);
    step(0, 1, 66, 40);
    repeat (3) step(0, 0, 0, 0);
  endtask

  task automatic test_press();
    keys = 24'(1) << 13;
    step(0, 1, 84, 10);
    step(1, 0, 0, 0);
    step(0, 1, 84, 10);
    step(0, 1, 80, 50);
    repeat (3) step(0, 0, 0, 0);
  endtask

  task automatic test_tail();
    keys = (24'(1) << 13) | (24'(1) << 12);
    step(1, 0, 0, 0);
    step(0, 1, 84, 10);
    step(0, 1, 80, 50);
    keys = '0;
    for (int f = 0; f < 10; f++) begin
      step(1, 0, 0, 0);
      step(0, 1, 84, 10);
      step(0, 1, 80, 50);
    end
    repeat (3) step(0, 0, 0, 0);
  endtask

  task automatic test_out_of_range();
    step(0, 1, 154, 50);
    step(0, 1, 200, 5);
    step(0, 1, 255, 127);
    step(0, 1, 153, 50);
    repeat (3) step(0, 0, 0, 0);
  endtask

  task automatic test_simultaneous();
    keys = 24'(1);
    step(1, 1, 0, 50);
    keys = 24'(1) << 5;
    step(0, 1, 0, 50);
    step(0, 1, 33, 50);
    keys = '0;
    step(0, 1, 33, 50);
    repeat (3) step(0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    keys = 24'(1) << 2;
    step(1, 1, 24, 50);
    keys = '0;
    for (int i = 0; i < 10; i++) step(1, 1, 24, 50);
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) == 0) keys = 24'($urandom());
      step($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
           int'($urandom_range(0, 255)), int'($urandom_range(0, 127)));
    end
    repeat (3) step(0, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    keys = (24'(1) << 13) | (24'(1) << 12);
    step(1, 0, 0, 0);
    keys = '0;
    step(1, 1, 84, 10);
    step(0, 1, 80, 50);
    dut_if.pix_valid = 1; dut_if.x = 8'd84; dut_if.y = 7'd10;
    rst_n = 1'b0;
    sb.delete();
    model_reset();
    @(posedge clk);
    #1;
    total++;
    if (dut_if.pix_valid_out !== 1'b0 || dut_if.color !== 3'h0 ||
        dut_if.key_hit !== 1'b0 || dut_if.key_idx !== 5'd0) begin
      bad++;
      $display("FAIL reset_mid got v=%0b col=%0h hit=%0b idx=%0d want all 0",
               dut_if.pix_valid_out, dut_if.color, dut_if.key_hit, dut_if.key_idx);
    end
    dut_if.pix_valid = 0;
    rst_n = 1'b1;
    step(0, 1, 84, 10);
    step(0, 1, 80, 50);
    step(1, 1, 84, 10);
    repeat (3) step(0, 0, 0, 0);
  endtask

  task automatic test_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 10) begin
      step(0, 0, 0, 0);
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain got pending=%0d want 0", sb.size());
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_static();
    test_press();
    test_tail();
    test_out_of_range();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    test_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
